weight_stream_loader: RTL
=========================

# weight_stream_loader

Upstream feeder for the `weight_memory` block. It accepts a flat stream of DATA_SIZE-bit words over a valid/ready handshake and converts each word into one write: the write strobe, the four write indices and the data. The stream carries one complete layer: every weight first, then every bias. The block sits between the host/DMA stream and `weight_memory`, and its outputs connect straight to that block's write ports.

## Interface
Parameters:
- NUM_INPUTS, 1, input-channel count; must match the connected weight memory.
- NUM_OUTPUTS, 1, output-channel count; also the number of bias words.
- DIM, 1, kernel side length; each (in, out) pair has DIM*DIM weights.
- DATA_SIZE, 64, word width (IEEE double bit pattern; passed through untouched).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin loading a layer; sampled only in IDLE.
- in_valid  in  1  in_data holds a valid word.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  DATA_SIZE  stream word.
- weight_write  out  1  registered write strobe for the weight array.
- bias_write  out  1  registered write strobe for the bias array.
- index_in  out  16  weight input-channel index.
- index_out  out  16  weight output-channel index.
- index_k_y  out  16  kernel row index.
- index_k_x  out  16  kernel column index for weights; bias index for biases.
- out_data  out  DATA_SIZE  registered copy of the accepted word.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, WEIGHTS, BIAS, DONE.
- **IDLE:**
  - start=1 → WEIGHTS. All counters clear to 0.
  - start is ignored in every other state.
- **Handshake:** a word is accepted at a rising edge where in_valid && in_ready. in_ready = (state==WEIGHTS || state==BIAS).
- **WEIGHTS:**
  - Counters are x, y, o, i. Order is x fastest, then y, then o, then i.
  - On each accept, x increments. When x==DIM-1, x wraps to 0 and y increments. The same wrap-and-carry applies y→o and o→i.
  - The accept where i==NUM_INPUTS-1, o==NUM_OUTPUTS-1, y==DIM-1, x==DIM-1 is the last weight. It moves the FSM to BIAS and clears x.
- **BIAS:**
  - x counts 0..NUM_OUTPUTS-1.
  - The accept with x==NUM_OUTPUTS-1 moves the FSM to DONE.
- **DONE:** lasts exactly one cycle, then → IDLE. done=1 only while in DONE.
- **Write outputs:** registered on the accepting edge.
  - Weight accept: weight_write=1, bias_write=0. index_in/out/k_y/k_x = the pre-increment i/o/y/x. out_data = in_data.
  - Bias accept: bias_write=1, weight_write=0. index_k_x = the pre-increment bias count. index_in, index_out, index_k_y are forced to 0.
  - Any cycle without an accept: both strobes = 0. Indices and out_data hold their last values.
  - weight_write and bias_write are never high together.
- **Widths:** counters are 16 bits and zero-extended onto the 16-bit index ports. Parameters must be ≤ 65535. The total word count NUM_INPUTS*NUM_OUTPUTS*DIM*DIM + NUM_OUTPUTS is not computed in hardware; termination uses the per-counter compares above.
- **Reset:** rst asserted at any time, including mid-layer, forces IDLE immediately. It clears all counters and drives every output to 0: in_ready, weight_write, bias_write, all indices, out_data, busy, done. A partially loaded layer is abandoned; the memory keeps whatever was already written.

## Timing
- in_ready rises the cycle after start is sampled (state = WEIGHTS).
- Latency is one cycle from an accept edge to the corresponding write strobe. The memory captures that write on the following edge.
- Sustained throughput: one word per cycle when in_valid is held high.
- in_valid low stalls the loader. No state or counter changes, and the strobes are 0.
- WEIGHTS→BIAS costs no bubble: in_ready stays high across the transition.
- The last bias accept edge enters DONE. In that same cycle bias_write=1 for the final bias and done=1. busy falls on the next edge.
- start asserted in the same cycle as done is ignored. A new layer needs start in IDLE.
- in_ready is a pure function of state and does not depend on in_valid.

## Test plan
- **Full load.** NUM_INPUTS=2, NUM_OUTPUTS=3, DIM=2; start, then 27 back-to-back words with value n = 0..26 → 24 weight_write pulses with (in, out, k_y, k_x) from (0,0,0,0) to (1,2,1,1) in x-fastest order, out_data=n; then 3 bias_write pulses with index_k_x=0,1,2 and data 24..26; done high on the cycle of the bias index 2 strobe; busy low one cycle later.
- **Stalls.** Same layer with in_valid toggled 1,0,0,1,… → strobes only on accept+1 cycles, sequence identical to the full-load case, and indices hold during gaps.
- **Start while busy.** Pulse start at word 10 → no counter reset; index sequence unchanged.
- **Reset mid-load.** Assert rst after the 7th weight accept → all outputs 0 immediately with no clock edge needed. A following start + 27 words restarts from (0,0,0,0).
- **Degenerate.** NUM_INPUTS=NUM_OUTPUTS=DIM=1: start, 2 words → one weight_write at (0,0,0,0), one bias_write at index 0, done pulses once.
- **Stray input.** in_valid=1 while IDLE or DONE → in_ready=0, no strobes.

Source files
------------

// File: rtl/weight_stream_loader_if.sv
// Word stream feeding weight_stream_loader: one DATA_SIZE-bit word per valid/ready beat.
interface weight_stream_loader_if #(
  parameter int DATA_SIZE = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/weight_stream_loader.sv
// Turns a flat layer stream (all weights, then all biases) into weight_memory write
// strobes with (in, out, k_y, k_x) indices and a registered copy of each word.
module weight_stream_loader #(
  parameter int NUM_INPUTS  = 1,
  parameter int NUM_OUTPUTS = 1,
  parameter int DIM         = 1,
  parameter int DATA_SIZE   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  weight_stream_loader_if.slave s_in,
  output logic                  weight_write,
  output logic                  bias_write,
  output logic [15:0]           index_in,
  output logic [15:0]           index_out,
  output logic [15:0]           index_k_y,
  output logic [15:0]           index_k_x,
  output logic [DATA_SIZE-1:0]  out_data,
  output logic                  busy,
  output logic                  done
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WEIGHTS = 2'd1;
  localparam logic [1:0] S_BIAS    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [15:0] DIM_LAST = 16'(DIM - 1);
  localparam logic [15:0] OUT_LAST = 16'(NUM_OUTPUTS - 1);
  localparam logic [15:0] IN_LAST  = 16'(NUM_INPUTS - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  // Counter slots: [0]=x (also the bias count), [1]=y, [2]=o, [3]=i
  logic [3:0][15:0]     r_cnt;
  logic [3:0][15:0]     w_cnt_next;
  logic [3:0][15:0]     w_last;
  logic [3:0]           w_wrap;
  logic [3:0]           w_carry;

  logic                 w_in_weights;
  logic                 w_in_bias;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_clear;
  logic                 w_last_weight;
  logic                 w_last_bias;

  logic                 r_weight_write;
  logic                 r_bias_write;
  logic [15:0]          r_index_in;
  logic [15:0]          r_index_out;
  logic [15:0]          r_index_k_y;
  logic [15:0]          r_index_k_x;
  logic [DATA_SIZE-1:0] r_out_data;

  assign w_in_weights = (r_state == S_WEIGHTS);
  assign w_in_bias    = (r_state == S_BIAS);
  assign w_ready      = w_in_weights | w_in_bias;
  assign w_accept     = s_in.in_valid & w_ready;
  assign w_clear      = (r_state == S_IDLE) & start;

  assign w_last[0] = w_in_bias ? OUT_LAST : DIM_LAST;
  assign w_last[1] = DIM_LAST;
  assign w_last[2] = OUT_LAST;
  assign w_last[3] = IN_LAST;

  // Ripple wrap-and-carry: a slot advances only when every faster slot wraps.
  assign w_carry[0] = w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      assign w_wrap[gi]     = (r_cnt[gi] == w_last[gi]);
      assign w_cnt_next[gi] = w_clear      ? 16'd0 :
                              !w_carry[gi] ? r_cnt[gi] :
                              w_wrap[gi]   ? 16'd0 :
                                             r_cnt[gi] + 16'd1;
      if (gi < 3) begin : g_chain
        assign w_carry[gi+1] = w_carry[gi] & w_wrap[gi] & w_in_weights;
      end
    end
  endgenerate

  assign w_last_weight = w_carry[3] & w_wrap[3];
  assign w_last_bias   = w_accept & w_in_bias & w_wrap[0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start)         w_state_next = S_WEIGHTS;
      S_WEIGHTS: if (w_last_weight) w_state_next = S_BIAS;
      S_BIAS:    if (w_last_bias)   w_state_next = S_DONE;
      default:                      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Write port: strobes pulse only on the cycle after an accept; indices/data hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_weight_write <= 1'b0;
      r_bias_write   <= 1'b0;
      r_index_in     <= '0;
      r_index_out    <= '0;
      r_index_k_y    <= '0;
      r_index_k_x    <= '0;
      r_out_data     <= '0;
    end else if (w_accept) begin
      r_weight_write <= w_in_weights;
      r_bias_write   <= w_in_bias;
      r_index_in     <= w_in_bias ? 16'd0 : r_cnt[3];
      r_index_out    <= w_in_bias ? 16'd0 : r_cnt[2];
      r_index_k_y    <= w_in_bias ? 16'd0 : r_cnt[1];
      r_index_k_x    <= r_cnt[0];
      r_out_data     <= s_in.in_data;
    end else begin
      r_weight_write <= 1'b0;
      r_bias_write   <= 1'b0;
    end
  end

  assign s_in.in_ready = w_ready;
  assign weight_write  = r_weight_write;
  assign bias_write    = r_bias_write;
  assign index_in      = r_index_in;
  assign index_out     = r_index_out;
  assign index_k_y     = r_index_k_y;
  assign index_k_x     = r_index_k_x;
  assign out_data      = r_out_data;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);

endmodule
